mem_port_arbiter: RTL

//  Shares the single unified instruction/data memory port between two masters:
//  - M0: the multicycle CPU (fetch, lw, sw).
//  - M1: the program loader/debug port.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter_rr_pick2.sv | 14 +
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and the round-robin pick rule for the two-master memory port arbiter.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'b00;
  localparam logic [1:0] ARB_ACCESS = 2'b01;
  localparam logic [1:0] ARB_RESP   = 2'b10;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_LDR = 1'b1;

  localparam int WAIT_W = 8;

  // A lone requester always wins; on a tie the master that did not go last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both master ports and the memory-side port of the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: a master raises mN_req with we/addr/wdata and holds it until mN_ack pulses
  // for one cycle, with mN_rdata/mN_err valid in that cycle; memory side, mem_en is held with
  // stable we/addr/wdata until mem_ready is seen high at a clock edge (or the wait times out).
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;
  logic              m1_err;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack, m1_err,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack, m1_err,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: which master (if any) wins this IDLE cycle.
module mem_port_arbiter_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);

  assign grant_valid = |req;
  assign grant_id    = rr_pick(req, last);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises M0 (CPU) and M1 (loader) onto one memory port: IDLE -> ACCESS -> RESP,
// round-robin on ties, and a bounded wait for mem_ready that ends in an error response.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        dbg_state
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAX_WAIT - 1);

  logic [1:0]        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              last_q;
  logic              winner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              err0_q;
  logic              err1_q;

  logic              grant_valid;
  logic              grant_id;
  logic              in_access;
  logic              timeout;
  logic              finish;
  logic [DATA_W-1:0] rdata_next;

  mem_port_arbiter_rr_pick2 u_pick (
    .req         ({bus.m1_req, bus.m0_req}),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign in_access = (state == ARB_ACCESS);
  // mem_ready takes priority over a timeout landing in the same cycle.
  assign timeout    = (wait_cnt == LAST_WAIT) && !bus.mem_ready;
  assign finish     = in_access && (bus.mem_ready || timeout);
  assign rdata_next = (bus.mem_ready && !we_q) ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ARB_IDLE;
      wait_cnt <= '0;
      last_q   <= 1'b1;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_valid) begin
            state    <= ARB_ACCESS;
            wait_cnt <= '0;
          end
        end
        ARB_ACCESS: begin
          if (finish) state <= ARB_RESP;
          else        wait_cnt <= wait_cnt + 1'b1;
        end
        ARB_RESP: begin
          last_q <= winner_q;
          state  <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      winner_q <= MASTER_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      if (state == ARB_IDLE && grant_valid) begin
        winner_q <= grant_id;
        we_q     <= grant_id ? bus.m1_we    : bus.m0_we;
        addr_q   <= grant_id ? bus.m1_addr  : bus.m0_addr;
        wdata_q  <= grant_id ? bus.m1_wdata : bus.m0_wdata;
      end
      // Only the winner's response registers move, so the other master's result is held.
      if (finish) begin
        if (winner_q == MASTER_LDR) begin
          rdata1_q <= rdata_next;
          err1_q   <= timeout;
        end else begin
          rdata0_q <= rdata_next;
          err0_q   <= timeout;
        end
      end
    end
  end

  assign bus.mem_en    = in_access;
  assign bus.mem_we    = in_access & we_q;
  assign bus.mem_addr  = in_access ? addr_q  : '0;
  assign bus.mem_wdata = in_access ? wdata_q : '0;

  assign bus.m0_ack   = (state == ARB_RESP) && (winner_q == MASTER_CPU);
  assign bus.m1_ack   = (state == ARB_RESP) && (winner_q == MASTER_LDR);
  assign bus.m0_rdata = rdata0_q;
  assign bus.m1_rdata = rdata1_q;
  assign bus.m0_err   = err0_q;
  assign bus.m1_err   = err1_q;

  assign dbg_state = state;

endmodule
